add_share_arb: RTL and testbench
================================

# add_share_arb

Round-robin arbiter and sequencer that shares one 10-bit ripple-carry adder (`adder_10`, instantiated inside this block) among `N_REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands, and registers the 11-bit sum. It then holds the result with the requester ID until the single response consumer accepts it. It sits between the ALU front-end request ports and the shared adder datapath.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(N_REQ)`: width of the requester ID; do not override.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `N_REQ`: bit i = requester i has an operand pair pending.
- `req_a`, in, `10*N_REQ`: requester i operand A at `[10i+9:10i]`, unsigned.
- `req_b`, in, `10*N_REQ`: requester i operand B at `[10i+9:10i]`, unsigned.
- `req_ready`, out, `N_REQ`: one-hot-or-zero grant; transfer for requester i when `req_valid[i] & req_ready[i]`.
- `rsp_valid`, out, 1: a result is held on `rsp_id`/`rsp_sum`.
- `rsp_id`, out, `IDW`: index of the requester that owns the result.
- `rsp_sum`, out, 11: `A+B`, unsigned, carry-in 0.
- `rsp_ready`, in, 1: the consumer accepts the result when `rsp_valid & rsp_ready`.
- `busy`, out, 1: high in CALC and RESP.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - `req_ready` is combinational, one-hot on the winning requester whenever any `req_valid` bit is set.
  - Winner is the first set `req_valid` bit searching upward from `(last+1) mod N_REQ`, wrapping around.
  - On transfer: latch `req_a[g]`, `req_b[g]`, and `g` into internal registers; set `last <= g`; go to CALC.
  - No valid request: stay in IDLE with `req_ready = 0`.
- **CALC**
  - The adder inputs are driven only from the latched operand registers.
  - Register the adder output into `rsp_sum` and the latched ID into `rsp_id`; set `rsp_valid <= 1`; go to RESP.
  - `req_ready = 0`.
- **RESP**
  - `rsp_valid = 1`; `rsp_id` and `rsp_sum` are held stable.
  - When `rsp_ready = 1`: clear `rsp_valid` and go to IDLE.
  - Otherwise stay in RESP indefinitely.
  - `req_ready = 0`.
- Requester rules:
  - A requester holds `req_valid` and its operands stable until granted.
  - A requester may withdraw `req_valid` before a grant. A withdrawn request consumes no grant and does not move `last`.
  - Requests arriving in CALC or RESP wait for the next IDLE.
- Arithmetic:
  - Zero-extend both operands to 11 bits and add; the result never overflows.
  - Maximum result is 1023 + 1023 = 2046.
- Reset (asserting `rst` at any time, including mid-CALC or mid-RESP, immediately forces all of the following):
  - state = IDLE.
  - `last = N_REQ-1`, so requester 0 has highest priority first.
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `busy = 0`, operand registers = 0.
  - `req_ready` is forced to 0 while `rst` is high.
  - An in-flight result is discarded and never presented.

## Timing
- Cycle T: handshake `req_valid[g] & req_ready[g]` in IDLE.
- T+1: CALC, `busy = 1`.
- T+2: RESP, with `rsp_valid = 1` and the correct `rsp_id`/`rsp_sum` visible.
- If `rsp_ready = 1` at T+2, the block is back in IDLE at T+3, and the earliest next grant is at T+3.
- Peak throughput is one operation per 3 cycles.
- Each cycle of `rsp_ready = 0` in RESP adds one cycle.
- `busy` is registered: high exactly in the CALC and RESP cycles.
- `req_ready` has a combinational path from `req_valid` only. There is no combinational path from `rsp_ready` to any output.

## Test plan
- **Single request.** After reset, requester 1 presents A=5, B=7.
  - `req_ready = 4'b0010` in the same cycle T.
  - At T+2: `rsp_valid = 1`, `rsp_id = 1`, `rsp_sum = 12`.
  - With `rsp_ready` held at 1, `rsp_valid` = 0 at T+3.
- **Width boundary.** A=1023, B=1023 gives `rsp_sum = 2046`. A=1023, B=1 gives 1024 (bit 10 set). A=0, B=0 gives 0.
- **Fairness.** All 4 requesters valid continuously from reset, requester i using A=i, B=100, `rsp_ready = 1`.
  - Grant order is 0,1,2,3,0,1.
  - Sums are 100,101,102,103,100,101.
  - Grants occur exactly every 3 cycles.
- **Wrap and skip.**
  - Only requester 2 is valid and is granted.
  - Next, requesters 0 and 3 are both valid: 3 is granted before 0.
- **Backpressure.** Hold `rsp_ready = 0` for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id`, and `rsp_sum` stay stable; `req_ready` stays 0 with all requests pending; `busy` stays 1.
  - Raising `rsp_ready` returns the block to IDLE on the next cycle.
- **Reset mid-operation.** Assert `rst` asynchronously in CALC.
  - `rsp_valid`, `rsp_sum`, and `busy` go to 0 without waiting for a clock edge.
  - After release, with requesters 0 and 2 valid, requester 0 is granted first and no stale result appears.

Source files
------------

// File: rtl/add_share_arb.sv
// Round-robin arbiter that time-shares one 10-bit ripple-carry adder among N_REQ
// valid/ready requesters and holds each 11-bit result until the consumer takes it.

module adder_10 (
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    output logic [10:0] sum
);
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < 10; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        sum[10] = carry;
    end
endmodule

module add_share_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [10*N_REQ-1:0]   req_a,
    input  logic [10*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [10:0]           rsp_sum,
    input  logic                  rsp_ready,
    output logic                  busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant_id;
    logic           grant_found;
    logic [9:0]     a_p0;
    logic [9:0]     b_p0;
    logic [IDW-1:0] id_p0;
    logic [10:0]    sum_p0;
    logic [9:0]     sel_a;
    logic [9:0]     sel_b;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        int gidx;
        gidx      = int'(grant_id);
        sel_a     = req_a[10*gidx +: 10];
        sel_b     = req_b[10*gidx +: 10];
        req_ready = '0;
        if (state == IDLE && grant_found && !rst)
            req_ready = N_REQ'(1) << grant_id;
    end

    adder_10 u_adder (
        .a   (a_p0),
        .b   (b_p0),
        .sum (sum_p0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDW'(N_REQ - 1);
            busy      <= 1'b0;
            a_p0      <= '0;
            b_p0      <= '0;
            id_p0     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            case (state)
                // stage p0: latch the winner's operands and ID
                IDLE: begin
                    if (grant_found) begin
                        a_p0  <= sel_a;
                        b_p0  <= sel_b;
                        id_p0 <= grant_id;
                        last  <= grant_id;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                // stage p1: register the adder result
                CALC: begin
                    rsp_sum   <= sum_p0;
                    rsp_id    <= id_p0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed scenarios plus random traffic, checked by a
// cycle-level reference model and a response scoreboard.

module tb_add_share_arb;
    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [10*N-1:0] req_a;
    logic [10*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [10:0]     rsp_sum;
    logic            rsp_ready;
    logic            busy;

    add_share_arb #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int sum;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_state  = 0;   // 0 idle, 1 computing, 2 result held
    int   m_last   = N - 1;
    int   granted  = -1;
    bit   keep     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[10*i +: 10] = 10'(a);
        req_b[10*i +: 10] = 10'(b);
        req_valid[i]      = 1'b1;
    endtask

    // One clock: check outputs against the model at the falling edge, then advance.
    task automatic step();
        int w;
        int seen;
        int nxt;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        w = -1;
        if (m_state == 0)
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (w < 0 && req_valid[i]) w = i;
            end
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_state != 0);
        chk("rsp_valid", rsp_valid, m_state == 2);
        seen = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) seen = i;
        if (seen >= 0) begin
            grant_log.push_back(seen);
            grant_cyc.push_back(cyc);
        end
        granted = w;
        nxt = m_state;
        if (w >= 0) begin
            sb.push_back('{w, int'(req_a[10*w +: 10]) + int'(req_b[10*w +: 10])});
            m_last = w;
            nxt = 1;
        end else if (m_state == 1) nxt = 2;
        else if (m_state == 2 && rsp_ready) nxt = 0;
        @(posedge clk);
        #1;
        cyc++;
        m_state = nxt;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            if (granted >= 0 && !keep) req_valid[granted] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        sb.delete();
        m_state = 0;
        m_last  = N - 1;
        @(posedge clk);
        #1;
        chk("rst_hold_req_ready", req_ready, 0);
        rst = 1'b0;
    endtask

    // Response monitor: pops the scoreboard on each accepted result.
    initial begin
        bit         hold;
        logic [1:0] p_id;
        logic [10:0] p_sum;
        exp_t       e;
        hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold && rsp_valid) begin
                    chk("hold_rsp_id", rsp_id, p_id);
                    chk("hold_rsp_sum", rsp_sum, p_sum);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected actual id=%0d sum=%0d required=no response", rsp_id, rsp_sum);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_sum", rsp_sum, e.sum);
                    end
                end
                hold  = rsp_valid && !rsp_ready;
                p_id  = rsp_id;
                p_sum = rsp_sum;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int order[6];
        order     = '{0, 1, 2, 3, 0, 1};
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #3;
        do_reset();

        // single request
        set_req(1, 5, 7);
        run(4);

        // width boundary
        set_req(2, 1023, 1023); run(3);
        set_req(0, 1023, 1);    run(3);
        set_req(3, 0, 0);       run(3);

        // fairness from reset
        for (int i = 0; i < N; i++) set_req(i, i, 100);
        do_reset();
        keep = 1;
        f0 = grant_log.size();
        run(18);
        keep = 0;
        req_valid = '0;
        run(3);
        chk("fair_count", grant_log.size() - f0 >= 6, 1);
        if (grant_log.size() - f0 >= 6)
            for (int k = 0; k < 6; k++) begin
                chk("fair_order", grant_log[f0+k], order[k]);
                if (k > 0) chk("fair_spacing", grant_cyc[f0+k] - grant_cyc[f0+k-1], 3);
            end

        // wrap and skip
        f0 = grant_log.size();
        set_req(2, 11, 22);
        run(3);
        set_req(0, 33, 44);
        set_req(3, 55, 66);
        run(6);
        chk("wrap_count", grant_log.size() - f0 >= 3, 1);
        if (grant_log.size() - f0 >= 3) begin
            chk("wrap_first", grant_log[f0], 2);
            chk("wrap_skip", grant_log[f0+1], 3);
            chk("wrap_then", grant_log[f0+2], 0);
        end
        run(3);

        // backpressure with all requests pending
        keep = 1;
        for (int i = 0; i < N; i++) set_req(i, 100 + i, 200 + i);
        run(2);
        rsp_ready = 1'b0;
        run(5);
        rsp_ready = 1'b1;
        run(2);
        keep = 0;
        req_valid = '0;
        run(4);

        // asynchronous reset while computing
        set_req(0, 9, 9);
        run(1);
        chk("calc_busy", busy, 1);
        set_req(0, 1, 2);
        set_req(2, 3, 4);
        f0 = grant_log.size();
        do_reset();
        run(8);
        chk("post_rst_count", grant_log.size() - f0 >= 2, 1);
        if (grant_log.size() - f0 >= 2) begin
            chk("post_rst_first", grant_log[f0], 0);
            chk("post_rst_second", grant_log[f0+1], 2);
        end

        // random traffic with withdrawals and backpressure
        for (int c = 0; c < 400; c++) begin
            run(1);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
                else if (req_valid[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        run(6);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
